// File: rtl/bsg_mem_1r1w_sync_arb.sv
// Shares one synchronous 1r1w RAM among several read and write clients using
// independent round-robin arbiters, with a one-entry response slot per reader.
module bsg_mem_1r1w_sync_arb #(
    parameter int width_p                = 8,
    parameter int els_p                  = 16,
    parameter int num_rd_p               = 4,
    parameter int num_wr_p               = 2,
    parameter bit read_write_same_addr_p = 1'b0,
    parameter int addr_width_lp          = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,

    input  logic [num_rd_p-1:0]               rd_v_i,
    input  logic [num_rd_p*addr_width_lp-1:0] rd_addr_i,
    output logic [num_rd_p-1:0]               rd_yumi_o,
    output logic [num_rd_p-1:0]               rd_v_o,
    output logic [num_rd_p*width_p-1:0]       rd_data_o,
    input  logic [num_rd_p-1:0]               rd_yumi_i,

    input  logic [num_wr_p-1:0]               wr_v_i,
    input  logic [num_wr_p*addr_width_lp-1:0] wr_addr_i,
    input  logic [num_wr_p*width_p-1:0]       wr_data_i,
    output logic [num_wr_p-1:0]               wr_yumi_o,

    output logic                              mem_w_v_o,
    output logic [addr_width_lp-1:0]          mem_w_addr_o,
    output logic [width_p-1:0]                mem_w_data_o,
    output logic                              mem_r_v_o,
    output logic [addr_width_lp-1:0]          mem_r_addr_o,
    input  logic [width_p-1:0]                mem_r_data_i
);

    localparam int rd_ptr_width_lp = (num_rd_p > 1) ? $clog2(num_rd_p) : 1;
    localparam int wr_ptr_width_lp = (num_wr_p > 1) ? $clog2(num_wr_p) : 1;

    typedef enum logic [1:0] {SLOT_EMPTY, SLOT_PEND, SLOT_HELD} slot_state_e;

    logic [addr_width_lp-1:0]   rd_addr [num_rd_p];
    logic [addr_width_lp-1:0]   wr_addr [num_wr_p];

    logic [rd_ptr_width_lp-1:0] rd_ptr_r, rd_ptr_n;
    logic [wr_ptr_width_lp-1:0] wr_ptr_r, wr_ptr_n;
    int                         rd_ptr_int, wr_ptr_int;
    int                         rd_grant_idx, wr_grant_idx;
    int                         rd_dist, wr_dist, rd_best_dist, wr_best_dist;
    logic                       rd_grant_v, wr_grant_v;
    logic [num_rd_p-1:0]        rd_elig;

    slot_state_e                slot_state_r [num_rd_p];
    slot_state_e                slot_state_n [num_rd_p];
    logic [width_p-1:0]         slot_data_r  [num_rd_p];
    logic [width_p-1:0]         slot_data_n  [num_rd_p];

    assign rd_ptr_int = int'(rd_ptr_r);
    assign wr_ptr_int = int'(wr_ptr_r);

    // A single-entry RAM has only one location, so every address collapses to 0.
    always_comb begin
        for (int j = 0; j < num_rd_p; j++) begin
            rd_addr[j] = (els_p == 1) ? '0 : rd_addr_i[j*addr_width_lp +: addr_width_lp];
        end
        for (int j = 0; j < num_wr_p; j++) begin
            wr_addr[j] = (els_p == 1) ? '0 : wr_addr_i[j*addr_width_lp +: addr_width_lp];
        end
    end

    always_comb begin
        wr_grant_v   = 1'b0;
        wr_grant_idx = 0;
        wr_dist      = 0;
        wr_best_dist = num_wr_p;
        if (!reset_i) begin
            for (int j = 0; j < num_wr_p; j++) begin
                wr_dist = (j >= wr_ptr_int) ? (j - wr_ptr_int) : (j + num_wr_p - wr_ptr_int);
                if (wr_v_i[j] && (wr_dist < wr_best_dist)) begin
                    wr_best_dist = wr_dist;
                    wr_grant_idx = j;
                    wr_grant_v   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        wr_yumi_o    = '0;
        mem_w_v_o    = wr_grant_v;
        mem_w_addr_o = '0;
        mem_w_data_o = '0;
        wr_ptr_n     = '0;
        for (int j = 0; j < num_wr_p; j++) begin
            if (wr_grant_v && (wr_grant_idx == j)) begin
                wr_yumi_o[j] = 1'b1;
                mem_w_addr_o = wr_addr[j];
                mem_w_data_o = wr_data_i[j*width_p +: width_p];
            end
        end
        if (wr_grant_idx < num_wr_p - 1) begin
            wr_ptr_n = wr_ptr_width_lp'(wr_grant_idx + 1);
        end
    end

    // A reader may be re-granted only if its slot frees up this cycle; writes win address collisions.
    always_comb begin
        rd_elig = '0;
        for (int j = 0; j < num_rd_p; j++) begin
            rd_elig[j] = !reset_i && rd_v_i[j]
                       && ((slot_state_r[j] == SLOT_EMPTY) || rd_yumi_i[j])
                       && !(!read_write_same_addr_p && mem_w_v_o && (rd_addr[j] == mem_w_addr_o));
        end
    end

    always_comb begin
        rd_grant_v   = 1'b0;
        rd_grant_idx = 0;
        rd_dist      = 0;
        rd_best_dist = num_rd_p;
        for (int j = 0; j < num_rd_p; j++) begin
            rd_dist = (j >= rd_ptr_int) ? (j - rd_ptr_int) : (j + num_rd_p - rd_ptr_int);
            if (rd_elig[j] && (rd_dist < rd_best_dist)) begin
                rd_best_dist = rd_dist;
                rd_grant_idx = j;
                rd_grant_v   = 1'b1;
            end
        end
    end

    always_comb begin
        rd_yumi_o    = '0;
        mem_r_v_o    = rd_grant_v;
        mem_r_addr_o = '0;
        rd_ptr_n     = '0;
        for (int j = 0; j < num_rd_p; j++) begin
            if (rd_grant_v && (rd_grant_idx == j)) begin
                rd_yumi_o[j] = 1'b1;
                mem_r_addr_o = rd_addr[j];
            end
        end
        if (rd_grant_idx < num_rd_p - 1) begin
            rd_ptr_n = rd_ptr_width_lp'(rd_grant_idx + 1);
        end
    end

    // PEND forwards the RAM output directly; the slot register only captures it under backpressure.
    always_comb begin
        rd_v_o    = '0;
        rd_data_o = '0;
        for (int j = 0; j < num_rd_p; j++) begin
            slot_state_n[j] = slot_state_r[j];
            slot_data_n[j]  = slot_data_r[j];
            case (slot_state_r[j])
                SLOT_EMPTY: begin
                    if (rd_yumi_o[j]) begin
                        slot_state_n[j] = SLOT_PEND;
                    end
                end
                SLOT_PEND: begin
                    rd_v_o[j]                          = 1'b1;
                    rd_data_o[j*width_p +: width_p]    = mem_r_data_i;
                    if (rd_yumi_i[j]) begin
                        slot_state_n[j] = rd_yumi_o[j] ? SLOT_PEND : SLOT_EMPTY;
                    end else begin
                        slot_state_n[j] = SLOT_HELD;
                        slot_data_n[j]  = mem_r_data_i;
                    end
                end
                SLOT_HELD: begin
                    rd_v_o[j]                          = 1'b1;
                    rd_data_o[j*width_p +: width_p]    = slot_data_r[j];
                    if (rd_yumi_i[j]) begin
                        slot_state_n[j] = rd_yumi_o[j] ? SLOT_PEND : SLOT_EMPTY;
                    end
                end
                default: begin
                    slot_state_n[j] = SLOT_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            for (int j = 0; j < num_rd_p; j++) begin
                slot_state_r[j] <= SLOT_EMPTY;
                slot_data_r[j]  <= '0;
            end
        end else begin
            if (rd_grant_v) begin
                rd_ptr_r <= rd_ptr_n;
            end
            if (wr_grant_v) begin
                wr_ptr_r <= wr_ptr_n;
            end
            for (int j = 0; j < num_rd_p; j++) begin
                slot_state_r[j] <= slot_state_n[j];
                slot_data_r[j]  <= slot_data_n[j];
            end
        end
    end

endmodule
